decoder_uart_streamer: RTL and testbench
========================================

Name: decoder_uart_streamer

Overview:
- Consumes the four 128-bit text lines produced by the instruction/ALU decoder and streams them out as an ASCII frame over a single 8N1 UART transmit pin, so CPU state can be read from a host terminal.
- Runs in the top-level fast clock domain, the same domain as the decoder.
- Takes a snapshot of all four lines on each accepted trigger. Later decoder updates therefore never tear a frame.

Parameters:
- BAUD_DIV, 434, clock cycles per UART bit (434 gives 115200 baud at 50 MHz). Legal minimum is 2; values below 2 are an elaboration error.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- trigger  input  1  frame request; sampled on rising clk edges
- line0  input  128  text line 0; 16 chars, char 0 in [127:120]
- line1  input  128  text line 1, same format
- line2  input  128  text line 2, same format
- line3  input  128  text line 3, same format
- tx  output  1  UART serial data, idle high
- busy  output  1  high while a frame is in progress
- done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset values (applied asynchronously): tx=1, busy=0, done=0, state=IDLE, all counters=0.
- All outputs are registered.
- Frame content:
  - 72 bytes total: for each line 0..3, 16 chars taken MSB-first ([127:120] first), then 0x0D, then 0x0A.
  - Character mapping applies to the 16 text chars only, never to CR/LF:
    - 0x00 is sent as 0x20.
    - Any other byte <0x20 or >0x7E is sent as 0x2E ('.').
    - 0x20..0x7E pass through unchanged.
- Accept rule:
  - trigger=1 sampled while state=IDLE accepts a frame.
  - On that edge all 512 line bits are latched into a snapshot register.
  - Also on that edge: busy becomes 1, state becomes START, tx becomes 0.
  - trigger sampled while busy is ignored. It is not queued.
- States:
  - IDLE: tx=1.
  - START: tx=0 for BAUD_DIV cycles.
  - DATA: 8 bits, LSB first, BAUD_DIV cycles each.
  - STOP: tx=1 for BAUD_DIV cycles.
- Counters:
  - baud_cnt counts 0..BAUD_DIV-1. Each bit ends when baud_cnt=BAUD_DIV-1.
  - bit_idx counts 0..7.
  - col counts 0..17.
  - line_idx counts 0..3.
- Transitions:
  - STOP end, not the last byte: advance col; when col wraps 17->0, increment line_idx. Go directly to START for the next byte, with no idle gap.
  - STOP end, last byte (line_idx=3, col=17): go to IDLE. On that same edge busy goes 0 and done goes 1 for exactly one cycle.
  - A trigger sampled in the cycle where done=1 is accepted, because the state is IDLE.
- Timing: frame length from the accept edge to the done edge is exactly 720*BAUD_DIV cycles.
- Snapshot isolation: changes on line0..3 during a frame have no effect on tx.
- Reset mid-frame:
  - tx returns high immediately, busy=0, state=IDLE.
  - done is not pulsed.
  - A partial byte is abandoned.
  - The next frame restarts at line 0, col 0.
- No back-pressure and no receive path.

Test Plan:
- Reset assertion: hold reset=1 with random inputs -> tx=1, busy=0, done=0. Assert reset asynchronously between clk edges -> tx goes high without waiting for an edge.
- Basic frame, BAUD_DIV=4, line0="A" followed by 15 zero bytes, other lines all 0x41 -> after trigger:
  - tx=0 for 4 cycles, then bits 1,0,0,0,0,0,1,0 for 4 cycles each, then 1 for 4 cycles.
  - Bytes 1..15 decode as 0x20, bytes 16-17 as 0x0D 0x0A.
  - The last byte is 0x0A.
  - done pulses exactly 2880 cycles after the accept edge, and busy falls on that same edge.
- Character mapping: line1 chars = 0x07, 0x7F, 0x7E, 0x20, 0x00, 0x1F, 0x80 -> received bytes 0x2E, 0x2E, 0x7E, 0x20, 0x20, 0x2E, 0x2E.
- Snapshot and ignored trigger:
  - Trigger with line2 = "ADDI x1,x0,5" zero-padded.
  - At cycle 100, change line2 to all 0x5A and pulse trigger again.
  - Expect: frame contains the original text, only one done pulse, total busy time 720*BAUD_DIV cycles.
- Back-to-back frames: hold trigger=1 continuously -> after each done pulse busy is low for exactly one cycle, then the next frame starts with a start bit. Two consecutive frames decode identically.
- Reset mid-frame: assert reset during bit 3 of byte 20 -> tx=1, busy=0, no done. After release and a new trigger, the first byte received is line0 char 0.

Source files
------------

// File: rtl/decoder_uart_streamer.sv
// Streams the decoder's four 16-character text lines as a 72-byte ASCII frame
// (each line followed by CR LF) over an 8N1 UART transmit pin.
module decoder_uart_streamer #(
    parameter int BAUD_DIV = 434
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         trigger,
    input  logic [127:0] line0,
    input  logic [127:0] line1,
    input  logic [127:0] line2,
    input  logic [127:0] line3,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    if (BAUD_DIV < 2) begin : g_bad_baud
        $error("decoder_uart_streamer: BAUD_DIV must be at least 2");
    end

    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Printable ASCII passes; NUL shows as space, other control/high bytes as '.'
    function automatic logic [7:0] map_char(input logic [7:0] c);
        logic [7:0] m;
        if (c == 8'h00) begin
            m = 8'h20;
        end else if ((c < 8'h20) || (c > 8'h7E)) begin
            m = 8'h2E;
        end else begin
            m = c;
        end
        return m;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [CW-1:0]    baud_cnt_r, baud_cnt_nxt_s;
    logic [2:0]       bit_idx_r, bit_idx_nxt_s;
    logic [4:0]       col_r, col_nxt_s;
    logic [1:0]       line_idx_r, line_idx_nxt_s;
    logic [3:0][127:0] snap_r;
    logic             tx_r, tx_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             done_r, done_nxt_s;
    logic             load_s;
    logic             bit_end_s;
    logic [127:0]     line_sel_s;
    logic [127:0]     line_shift_s;
    logic [7:0]       cur_byte_s;

    assign tx        = tx_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign bit_end_s = (baud_cnt_r == BAUD_LAST);

    // Byte currently being serialised: mapped text char, or CR/LF at columns 16/17
    always_comb begin
        line_sel_s   = snap_r[line_idx_r];
        line_shift_s = line_sel_s >> {4'd15 - col_r[3:0], 3'b000};
        if (col_r == 5'd16) begin
            cur_byte_s = 8'h0D;
        end else if (col_r == 5'd17) begin
            cur_byte_s = 8'h0A;
        end else begin
            cur_byte_s = map_char(line_shift_s[7:0]);
        end
    end

    // Next-state, counter and output logic of the bit/byte sequencer
    always_comb begin
        state_nxt_s    = state_r;
        baud_cnt_nxt_s = baud_cnt_r;
        bit_idx_nxt_s  = bit_idx_r;
        col_nxt_s      = col_r;
        line_idx_nxt_s = line_idx_r;
        tx_nxt_s       = tx_r;
        busy_nxt_s     = busy_r;
        done_nxt_s     = 1'b0;
        load_s         = 1'b0;
        case (state_r)
            S_IDLE: begin
                tx_nxt_s       = 1'b1;
                baud_cnt_nxt_s = '0;
                bit_idx_nxt_s  = 3'd0;
                col_nxt_s      = 5'd0;
                line_idx_nxt_s = 2'd0;
                if (trigger) begin
                    state_nxt_s = S_START;
                    tx_nxt_s    = 1'b0;
                    busy_nxt_s  = 1'b1;
                    load_s      = 1'b1;
                end else begin
                    busy_nxt_s  = 1'b0;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    baud_cnt_nxt_s = '0;
                    bit_idx_nxt_s  = 3'd0;
                    state_nxt_s    = S_DATA;
                    tx_nxt_s       = cur_byte_s[0];
                end else begin
                    baud_cnt_nxt_s = baud_cnt_r + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    baud_cnt_nxt_s = '0;
                    if (bit_idx_r == 3'd7) begin
                        bit_idx_nxt_s = 3'd0;
                        state_nxt_s   = S_STOP;
                        tx_nxt_s      = 1'b1;
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                        tx_nxt_s      = cur_byte_s[bit_idx_r + 3'd1];
                    end
                end else begin
                    baud_cnt_nxt_s = baud_cnt_r + BAUD_ONE;
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    baud_cnt_nxt_s = '0;
                    if ((line_idx_r == 2'd3) && (col_r == 5'd17)) begin
                        state_nxt_s    = S_IDLE;
                        col_nxt_s      = 5'd0;
                        line_idx_nxt_s = 2'd0;
                        tx_nxt_s       = 1'b1;
                        busy_nxt_s     = 1'b0;
                        done_nxt_s     = 1'b1;
                    end else if (col_r == 5'd17) begin
                        state_nxt_s    = S_START;
                        col_nxt_s      = 5'd0;
                        line_idx_nxt_s = line_idx_r + 2'd1;
                        tx_nxt_s       = 1'b0;
                    end else begin
                        state_nxt_s    = S_START;
                        col_nxt_s      = col_r + 5'd1;
                        tx_nxt_s       = 1'b0;
                    end
                end else begin
                    baud_cnt_nxt_s = baud_cnt_r + BAUD_ONE;
                end
            end
            default: begin
                state_nxt_s    = S_IDLE;
                baud_cnt_nxt_s = '0;
                bit_idx_nxt_s  = 3'd0;
                col_nxt_s      = 5'd0;
                line_idx_nxt_s = 2'd0;
                tx_nxt_s       = 1'b1;
                busy_nxt_s     = 1'b0;
            end
        endcase
    end

    // State, counters, registered outputs and the frame snapshot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            baud_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            col_r      <= 5'd0;
            line_idx_r <= 2'd0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            snap_r     <= '0;
        end else begin
            state_r    <= state_nxt_s;
            baud_cnt_r <= baud_cnt_nxt_s;
            bit_idx_r  <= bit_idx_nxt_s;
            col_r      <= col_nxt_s;
            line_idx_r <= line_idx_nxt_s;
            tx_r       <= tx_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            if (load_s) begin
                snap_r <= {line3, line2, line1, line0};
            end else begin
                snap_r <= snap_r;
            end
        end
    end

endmodule

// File: tb/tb_decoder_uart_streamer.sv
// Directed bench for decoder_uart_streamer at BAUD_DIV=4: records tx/busy/done
// every cycle and decodes the UART frame from the recorded waveform.
module tb_decoder_uart_streamer;

    localparam int BD    = 4;
    localparam int FRAME = 720 * BD;
    localparam int HMAX  = 32768;

    logic         clk = 1'b0;
    logic         reset;
    logic         trigger;
    logic [127:0] line0, line1, line2, line3;
    logic         tx, busy, done;

    decoder_uart_streamer #(.BAUD_DIV(BD)) dut (
        .clk     (clk),
        .reset   (reset),
        .trigger (trigger),
        .line0   (line0),
        .line1   (line1),
        .line2   (line2),
        .line3   (line3),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    logic tx_h   [HMAX];
    logic busy_h [HMAX];
    logic done_h [HMAX];
    int   cyc = 0;

    // Sample index n holds the outputs seen between rising edges n and n+1
    always @(negedge clk) begin
        if (cyc < HMAX) begin
            tx_h[cyc]   <= tx;
            busy_h[cyc] <= busy;
            done_h[cyc] <= done;
        end
        cyc <= cyc + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] dec_byte(input int c, input int k);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) begin
            b[j] = tx_h[c + (k * 10 + j + 1) * BD + BD / 2];
        end
        return b;
    endfunction

    function automatic int framing_errs(input int c);
        int n = 0;
        for (int k = 0; k < 72; k++) begin
            if (tx_h[c + k * 10 * BD + BD / 2] !== 1'b0) n++;
            if (tx_h[c + (k * 10 + 9) * BD + BD / 2] !== 1'b1) n++;
        end
        return n;
    endfunction

    function automatic int count_ones_done(input int from, input int to);
        int n = 0;
        for (int i = from; i <= to; i++) if (done_h[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_ones_busy(input int from, input int to);
        int n = 0;
        for (int i = from; i <= to; i++) if (busy_h[i] === 1'b1) n++;
        return n;
    endfunction

    typedef struct { int pos; logic [7:0] exp; } pos_vec_t;
    typedef struct { logic [7:0] ch; logic [7:0] exp; } map_vec_t;

    pos_vec_t basic_tbl [8];
    map_vec_t map_tbl   [10];

    initial begin
        int          c0, c1, n, wlvl;
        logic [7:0]  exp_a [72];
        logic [7:0]  a_ch;
        logic [95:0] addi_txt;
        logic [127:0] hello;

        basic_tbl = '{'{0, 8'h41}, '{1, 8'h20}, '{15, 8'h20}, '{16, 8'h0D},
                      '{17, 8'h0A}, '{18, 8'h41}, '{53, 8'h0A}, '{71, 8'h0A}};
        map_tbl   = '{'{8'h07, 8'h2E}, '{8'h7F, 8'h2E}, '{8'h7E, 8'h7E}, '{8'h20, 8'h20},
                      '{8'h00, 8'h20}, '{8'h1F, 8'h2E}, '{8'h80, 8'h2E}, '{8'h41, 8'h41},
                      '{8'hFF, 8'h2E}, '{8'h0D, 8'h2E}};
        a_ch     = 8'h41;
        addi_txt = "ADDI x1,x0,5";
        hello    = "Hello streamer!!";

        // Reset held with random inputs
        reset   = 1'b1;
        trigger = 1'b0;
        line0 = {$urandom, $urandom, $urandom, $urandom};
        line1 = line0; line2 = line0; line3 = line0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_tx", tx, 1);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            trigger = 1'($urandom);
            line0 = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        reset   = 1'b0;
        trigger = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_tx", tx, 1);
        check("idle_busy", busy, 0);

        // Basic frame
        line0 = {8'h41, 120'h0};
        line1 = {16{8'h41}};
        line2 = {16{8'h41}};
        line3 = {16{8'h41}};
        @(negedge clk); trigger = 1'b1;
        @(posedge clk); c0 = cyc;
        @(negedge clk); trigger = 1'b0;
        repeat (FRAME + 10) @(negedge clk);
        #1;
        n = 0;
        for (int i = 0; i < 10 * BD; i++) begin
            if (i / BD == 0) wlvl = 0;
            else if (i / BD == 9) wlvl = 1;
            else wlvl = a_ch[i / BD - 1];
            if (tx_h[c0 + i] !== wlvl[0]) n++;
        end
        check("byte0_wave", n, 0);
        check("basic_framing", framing_errs(c0), 0);
        foreach (basic_tbl[i]) check("basic_byte", dec_byte(c0, basic_tbl[i].pos), basic_tbl[i].exp);
        for (int k = 0; k < 72; k++) begin
            if (k % 18 == 16) exp_a[k] = 8'h0D;
            else if (k % 18 == 17) exp_a[k] = 8'h0A;
            else if (k / 18 == 0) exp_a[k] = (k == 0) ? 8'h41 : 8'h20;
            else exp_a[k] = 8'h41;
        end
        n = 0;
        for (int k = 0; k < 72; k++) if (dec_byte(c0, k) !== exp_a[k]) n++;
        check("basic_all_bytes", n, 0);
        check("done_at_end", done_h[c0 + FRAME], 1);
        check("busy_fall_at_end", busy_h[c0 + FRAME], 0);
        check("busy_before_end", busy_h[c0 + FRAME - 1], 1);
        check("done_early", done_h[c0 + FRAME - 1], 0);
        check("done_pulses", count_ones_done(c0, c0 + FRAME + 9), 1);

        // Character mapping on line1
        for (int i = 0; i < 16; i++) line1[127 - 8 * i -: 8] = (i < 10) ? map_tbl[i].ch : 8'h41;
        @(negedge clk); trigger = 1'b1;
        @(posedge clk); c0 = cyc;
        @(negedge clk); trigger = 1'b0;
        repeat (FRAME + 10) @(negedge clk);
        #1;
        foreach (map_tbl[i]) check("map_char", dec_byte(c0, 18 + i), map_tbl[i].exp);
        check("map_cr", dec_byte(c0, 34), 8'h0D);
        check("map_lf", dec_byte(c0, 35), 8'h0A);

        // Snapshot isolation and ignored trigger
        line2 = {addi_txt, 32'h0};
        @(negedge clk); trigger = 1'b1;
        @(posedge clk); c0 = cyc;
        @(negedge clk); trigger = 1'b0;
        repeat (99) @(negedge clk);
        line2   = {16{8'h5A}};
        trigger = 1'b1;
        @(negedge clk); trigger = 1'b0;
        repeat (FRAME + 40 - 101) @(negedge clk);
        #1;
        n = 0;
        for (int i = 0; i < 12; i++) if (dec_byte(c0, 36 + i) !== addi_txt[95 - 8 * i -: 8]) n++;
        for (int i = 12; i < 16; i++) if (dec_byte(c0, 36 + i) !== 8'h20) n++;
        check("snap_text", n, 0);
        check("snap_busy_len", count_ones_busy(c0, c0 + FRAME + 39), FRAME);
        check("snap_one_done", count_ones_done(c0, c0 + FRAME + 39), 1);
        n = 0;
        for (int i = FRAME; i < FRAME + 40; i++) if (tx_h[c0 + i] !== 1'b1) n++;
        check("no_queued_frame", n, 0);

        // Back-to-back frames with trigger held high
        @(negedge clk); trigger = 1'b1;
        @(posedge clk); c0 = cyc;
        repeat (2 * FRAME + 4) @(negedge clk);
        #1;
        trigger = 1'b0;
        c1 = c0 + FRAME + 1;
        check("b2b_busy_hi", busy_h[c0 + FRAME - 1], 1);
        check("b2b_done", done_h[c0 + FRAME], 1);
        check("b2b_gap", busy_h[c0 + FRAME], 0);
        check("b2b_restart", busy_h[c1], 1);
        check("b2b_start_bit", tx_h[c1], 0);
        check("b2b_gap2", busy_h[c1 + FRAME], 0);
        check("b2b_restart2", busy_h[c1 + FRAME + 1], 1);
        n = 0;
        for (int k = 0; k < 72; k++) if (dec_byte(c0, k) !== dec_byte(c1, k)) n++;
        check("b2b_identical", n, 0);
        check("b2b_line2", dec_byte(c1, 36), 8'h5A);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        check("clear_busy", busy, 0);

        // Reset in the middle of bit 3 of byte 20
        line0 = hello;
        line1 = {16{8'h41}};
        @(negedge clk); trigger = 1'b1;
        @(posedge clk); c0 = cyc;
        @(negedge clk); trigger = 1'b0;
        repeat (817) @(negedge clk);
        #2;
        check("mid_tx_before", tx, 0);
        check("mid_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_async_tx", tx, 1);
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("mid_no_done", count_ones_done(c0, cyc - 1), 0);
        check("mid_idle_tx", tx, 1);
        @(negedge clk); trigger = 1'b1;
        @(posedge clk); c1 = cyc;
        @(negedge clk); trigger = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        check("restart_byte0", dec_byte(c1, 0), 8'h48);
        check("restart_byte1", dec_byte(c1, 1), 8'h65);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
